// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multi-cycle controller: FSM states, Op classes,
// datapath select codes and extender modes.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10
   } state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/instr_dec.sv
// Combinational Op decode for the immediate extender mode and register-file
// read-port selects; shared with the single-cycle decoder.
module instr_dec
   import arm_ctrl_pkg::*;
(
   input  logic [1:0] op,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src
);

   always_comb begin
      unique case (op)
         OP_MEM:  imm_src = IMM_MEM;
         OP_BR:   imm_src = IMM_BR;
         default: imm_src = IMM_DP;
      endcase
   end

   // Branches read the PC on port 1; stores read Rd on port 2.
   assign reg_src = {op == OP_MEM, op == OP_BR};

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller FSM for the ARM core.
// Optional feature: define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module multicycle_ctrl
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       PCS,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       Illegal
);

`ifdef MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   state_e state_q, state_d;
   state_e out_state;
   ctrl_t  ctrl;
   logic   mem_go;
   logic   unused_funct;

   assign mem_go       = !WAIT_EN || MemReady;
   assign unused_funct = ^Funct[4:1];

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:    if (mem_go) state_d = S_DECODE;
         S_DECODE: begin
            unique case (Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_go) state_d = S_FETCH;
         S_EXECUTER,
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Selects show FETCH values while reset is held, before the state flop has caught up.
   assign out_state = reset ? S_FETCH : state_q;

   always_comb begin
      ctrl = CTRL_IDLE;
      unique case (out_state)
         S_FETCH: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALU;
            ctrl.ir_write   = mem_go;
            ctrl.next_pc    = mem_go;
         end
         S_DECODE: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALU;
         end
         S_MEMADR:   ctrl.alu_src_b = SRCB_IMM;
         S_MEMREAD:  ctrl.adr_src   = 1'b1;
         S_MEMWB: begin
            ctrl.result_src = RES_RDATA;
            ctrl.reg_w      = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.adr_src = 1'b1;
            ctrl.mem_w   = 1'b1;
         end
         S_EXECUTER: ctrl.alu_op = 1'b1;
         S_EXECUTEI: begin
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = 1'b1;
         end
         S_ALUWB:    ctrl.reg_w = 1'b1;
         S_BRANCH: begin
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.result_src = RES_ALU;
            ctrl.branch     = 1'b1;
         end
         S_UNKNOWN:  ctrl.illegal = 1'b1;
         default:    ctrl = CTRL_IDLE;
      endcase
   end

   assign AdrSrc    = ctrl.adr_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ResultSrc = ctrl.result_src;
   assign ALUOp     = ctrl.alu_op;

   // Strobes are killed during reset so an abandoned instruction never writes.
   assign IRWrite = ctrl.ir_write & ~reset;
   assign NextPC  = ctrl.next_pc  & ~reset;
   assign RegW    = ctrl.reg_w    & ~reset;
   assign MemW    = ctrl.mem_w    & ~reset;
   assign Branch  = ctrl.branch   & ~reset;
   assign Illegal = ctrl.illegal  & ~reset;
   assign PCS     = Branch | (RegW & (Rd == 4'd15));

   instr_dec u_instr_dec (
      .op      (Op),
      .imm_src (ImmSrc),
      .reg_src (RegSrc)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction phase model.
module tb_multicycle_ctrl;

`ifdef MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                 P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_UNK} phase_e;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'b0;
   logic [3:0] Rd = 4'd0;
   logic       MemReady = 1'b1;
   logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, PCS, Illegal;
   logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;

   int tests_run = 0;
   int tests_failed = 0;
   phase_e plan[$];

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
      .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
      .MemW(MemW), .Branch(Branch), .PCS(PCS), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   // Field order: IRWrite NextPC AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp RegW MemW Branch PCS ImmSrc RegSrc Illegal
   function automatic logic [17:0] dut_vec();
      return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
              RegW, MemW, Branch, PCS, ImmSrc, RegSrc, Illegal};
   endfunction

   function automatic logic [17:0] expected(phase_e p, logic [1:0] op, logic [3:0] rd,
                                            bit ready, bit in_reset);
      logic irw = 0, npc = 0, adr = 0, asa = 0, aluop = 0, regw = 0, memw = 0, br = 0, ill = 0, pcs;
      logic [1:0] asb = 0, rs = 0, imm, rsrc;
      case (p)
         P_FETCH:    begin asa = 1; asb = 2; rs = 2; irw = !WAIT_EN || ready; npc = irw; end
         P_DECODE:   begin asa = 1; asb = 2; rs = 2; end
         P_MEMADR:   asb = 1;
         P_MEMREAD:  adr = 1;
         P_MEMWB:    begin rs = 1; regw = 1; end
         P_MEMWRITE: begin adr = 1; memw = 1; end
         P_EXECR:    aluop = 1;
         P_EXECI:    begin asb = 1; aluop = 1; end
         P_ALUWB:    regw = 1;
         P_BRANCH:   begin asb = 1; rs = 2; br = 1; end
         default:    ill = 1;
      endcase
      if (in_reset) begin irw = 0; npc = 0; regw = 0; memw = 0; br = 0; ill = 0; end
      imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
      rsrc = {op == 2'b01, op == 2'b10};
      pcs  = br | (regw && rd == 4'd15);
      return {irw, npc, adr, asa, asb, rs, aluop, regw, memw, br, pcs, imm, rsrc, ill};
   endfunction

   // Phase sequence of one instruction, derived from its class alone.
   task automatic build_plan(logic [1:0] op, logic [5:0] funct);
      plan.delete();
      plan.push_back(P_FETCH);
      plan.push_back(P_DECODE);
      case (op)
         2'b00: begin
            plan.push_back(funct[5] ? P_EXECI : P_EXECR);
            plan.push_back(P_ALUWB);
         end
         2'b01: begin
            plan.push_back(P_MEMADR);
            if (funct[0]) begin plan.push_back(P_MEMREAD); plan.push_back(P_MEMWB); end
            else          plan.push_back(P_MEMWRITE);
         end
         2'b10:   plan.push_back(P_BRANCH);
         default: plan.push_back(P_UNK);
      endcase
   endtask

   // Runs one instruction cycle by cycle; waits < 0 means random; reset_at aborts at that phase.
   task automatic run_instr(string name, logic [1:0] op, logic [5:0] funct, logic [3:0] rd,
                            int fetch_waits, int mem_waits, int reset_at);
      logic [17:0] exp;
      int nw;
      Op = op; Funct = funct; Rd = rd;
      build_plan(op, funct);
      foreach (plan[i]) begin
         nw = 0;
         if (WAIT_EN && plan[i] == P_FETCH)
            nw = (fetch_waits < 0) ? int'($urandom_range(0, 2)) : fetch_waits;
         else if (WAIT_EN && (plan[i] == P_MEMREAD || plan[i] == P_MEMWRITE))
            nw = (mem_waits < 0) ? int'($urandom_range(0, 2)) : mem_waits;
         for (int w = 0; w < nw; w++) begin
            MemReady = 1'b0;
            @(negedge clk);
            exp = expected(plan[i], op, rd, 1'b0, 1'b0);
            tests_run++;
            if (dut_vec() !== exp) begin
               tests_failed++;
               $display("FAIL %s wait %s: got %h expected %h", name, plan[i].name(), dut_vec(), exp);
            end
            @(posedge clk); #1;
         end
         if (i == reset_at) begin
            reset = 1'b1;
            MemReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp = expected(P_FETCH, op, rd, MemReady, 1'b1);
            tests_run++;
            if (dut_vec() !== exp) begin
               tests_failed++;
               $display("FAIL %s reset in %s: got %h expected %h", name, plan[i].name(), dut_vec(), exp);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         MemReady = WAIT_EN ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         exp = expected(plan[i], op, rd, MemReady, 1'b0);
         tests_run++;
         if (dut_vec() !== exp) begin
            tests_failed++;
            $display("FAIL %s %s: got %h expected %h", name, plan[i].name(), dut_vec(), exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [17:0] exp;
      reset = 1'b1; Op = 2'b00; Rd = 4'd15; MemReady = 1'b1;
      repeat (2) begin
         @(negedge clk);
         exp = expected(P_FETCH, Op, Rd, 1'b1, 1'b1);
         tests_run++;
         if (dut_vec() !== exp) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec(), exp);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   task automatic test_add_imm();
      run_instr("add_imm", 2'b00, 6'b101000, 4'd3, 0, 0, -1);
   endtask

   task automatic test_ldr_wait();
      run_instr("ldr_wait", 2'b01, 6'b011001, 4'd5, 1, 3, -1);
   endtask

   task automatic test_str();
      run_instr("str", 2'b01, 6'b011000, 4'd2, -1, 2, -1);
   endtask

   task automatic test_branch();
      run_instr("branch", 2'b10, 6'b100000, 4'd0, 0, 0, -1);
   endtask

   task automatic test_mov_pc();
      run_instr("mov_pc", 2'b00, 6'b011010, 4'd15, 0, 0, -1);
   endtask

   task automatic test_illegal();
      run_instr("illegal", 2'b11, 6'b000000, 4'd15, 0, 0, -1);
   endtask

   task automatic test_reset_memwrite();
      run_instr("reset_memwrite", 2'b01, 6'b011000, 4'd1, 0, 2, 3);
      run_instr("after_reset", 2'b00, 6'b000100, 4'd4, 0, 0, -1);
   endtask

   task automatic test_back_to_back();
      logic [1:0] op;
      int abort;
      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(0, 3));
         build_plan(op, 6'b0);
         abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr("random", op, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                   -1, -1, abort);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add_imm();
      test_ldr_wait();
      test_str();
      test_branch();
      test_mov_pc();
      test_illegal();
      test_reset_memwrite();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main controller for the ARM core. Sequences fetch, decode, execute, memory and writeback over several cycles so one ALU, one memory port and the immediate extender are shared across instruction phases. Drives the datapath mux selects, write strobes, `ALUOp` and the extender's `ImmSrc`. Condition checking and ALU decode stay in the existing conditional-logic and ALU-decoder blocks.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Op`  in  2  `Instr[27:26]`: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `Funct`  in  6  `Instr[25:20]`: bit 5 = immediate operand, bit 0 = load/L bit.
- `Rd`  in  4  `Instr[15:12]`; used for PC-write detection.
- `MemReady`  in  1  memory handshake. Used only with `MEM_WAIT_EN`; ignored otherwise.
- `IRWrite`  out  1  instruction-register load strobe.
- `NextPC`  out  1  PC <= PC+4 strobe.
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALU result.
- `ALUSrcA`  out  1  0 = register A, 1 = PC.
- `ALUSrcB`  out  2  00 = register B, 01 = `ExtImm`, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUOp`  out  1  1 = ALU decoder uses `Funct`; 0 = add.
- `RegW`, `MemW`, `Branch`  out  1 each  unconditioned write strobes, passed to conditional logic.
- `PCS`  out  1  `Branch`, or (`RegW` and `Rd` == 15).
- `ImmSrc`  out  2  extender mode: `Op` 00 -> 00, 01 -> 01, 10 -> 10, 11 -> 00.
- `RegSrc`  out  2  bit0 = (`Op` == 10), bit1 = (`Op` == 01).
- `Illegal`  out  1  one-cycle pulse on reaching the UNKNOWN state.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR when `Op` = 01.
  - DECODE -> EXECUTER when `Op` = 00 and `Funct[5]` = 0.
  - DECODE -> EXECUTEI when `Op` = 00 and `Funct[5]` = 1.
  - DECODE -> BRANCH when `Op` = 10.
  - DECODE -> UNKNOWN when `Op` = 11.
  - MEMADR -> MEMREAD when `Funct[0]` = 1, else -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER and EXECUTEI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH and UNKNOWN -> FETCH.
- Outputs are Moore, decoded from the state. `ImmSrc`, `RegSrc` and `PCS` also use `Op` and `Rd`. Every field not listed for a state drives 0.
  - FETCH: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, `IRWrite`=1, `NextPC`=1.
  - DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - MEMADR: `ALUSrcB`=01.
  - MEMREAD: `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegW`=1.
  - MEMWRITE: `AdrSrc`=1, `MemW`=1.
  - EXECUTER: `ALUOp`=1.
  - EXECUTEI: `ALUSrcB`=01, `ALUOp`=1.
  - ALUWB: `RegW`=1.
  - BRANCH: `ALUSrcB`=01, `ResultSrc`=10, `Branch`=1.
  - UNKNOWN: `Illegal`=1; no write strobes.
- Reset:
  - While `reset` is high, `IRWrite`, `NextPC`, `RegW`, `MemW`, `Branch` and `Illegal` are forced to 0.
  - State becomes FETCH on the next edge, including when reset is asserted mid-instruction. The partial instruction is abandoned with no register or memory write.
  - Selects show FETCH values during reset.

## Timing
- Cycles per instruction (no wait states): data-processing 4, LDR 5, STR 4, B 3, illegal 3.
- State register updates only on `clk` edges. All outputs settle combinationally within the cycle of their state.
- `ImmSrc` is valid from DECODE onward; the instruction register is stable from that point.

## Configuration
- `MEM_WAIT_EN` defined: FETCH, MEMREAD and MEMWRITE hold until `MemReady` = 1.
  - In FETCH, `IRWrite` and `NextPC` assert only in the cycle where `MemReady` = 1, so the PC increments exactly once.
  - `MemW` holds high for every cycle spent in MEMWRITE.
  - A reset during a wait returns the FSM to FETCH.
- `MEM_WAIT_EN` undefined: `MemReady` is ignored and every state lasts exactly one cycle.

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - the state encoding (4-bit, FETCH = 0);
  - `Op` constants;
  - `ALUSrcB` and `ResultSrc` select encodings;
  - `ImmSrc` encodings, shared with the extender.
- Sub-module `instr_dec`: combinational `Op`-to-`ImmSrc`/`RegSrc` decode, reused by the single-cycle decoder.

## Test plan
- Reset held for 2 cycles, then released:
  - write strobes are 0 during reset;
  - the first post-reset cycle is FETCH with `IRWrite` = 1, `NextPC` = 1, `ALUSrcB` = 10.
- ADD immediate (`Op` = 00, `Funct` = 101000, `Rd` = 3):
  - sequence FETCH, DECODE, EXECUTEI, ALUWB;
  - `ImmSrc` = 00, `ALUOp` = 1 in EXECUTEI, `RegW` = 1 in ALUWB, `PCS` = 0.
- LDR with `MEM_WAIT_EN` and `MemReady` low for 3 cycles in MEMREAD:
  - MEMREAD lasts 4 cycles, then MEMWB with `ResultSrc` = 01, `RegW` = 1;
  - `ImmSrc` = 01.
- Branch (`Op` = 10):
  - 3 cycles total; BRANCH shows `Branch` = 1, `PCS` = 1, `ImmSrc` = 10, `RegSrc` = 01.
- MOV to PC (`Op` = 00, `Rd` = 15):
  - `PCS` = 1 in ALUWB.
- `Op` = 11:
  - `Illegal` pulses 1 cycle with no strobes, then FETCH.
- Reset in MEMWRITE:
  - `MemW` = 0 in the reset cycle;
  - the next state is FETCH.
